mux_arbiter_mod: RTL and testbench

//  Round-robin arbiter sharing one 8-bit-to-16-bit result channel between four requesters (A..D).

---
 rtl/mux_arbiter_mod.sv | 112 +++++++++++
 tb/tb_mux_arbiter_mod.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mux_arbiter_mod.sv
// Round-robin arbiter + result register for four requesters; grant is combinational, result appears one cycle later.
// A stalled result (R_VALID & !R_READY) blocks all grants, so no data is ever overwritten.
module mux_arbiter_mod #(
  parameter int DW    = 8,
  parameter int BURST = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [3:0]    REQ,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [DW-1:0] C,
  input  logic [DW-1:0] D,
  output logic [3:0]    GNT,
  output logic [2*DW-1:0] R,
  output logic [1:0]    R_ID,
  output logic          R_VALID,
  input  logic          R_READY,
  output logic          en
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] r_dat;
  logic [1:0]    last;
  logic [CW-1:0] cnt;

  logic          free;
  logic          others;
  logic          rpt;
  logic          found;
  logic          xfer;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic [DW-1:0] sel_dat;

  always_comb begin
    GNT    = 4'b0000;
    win    = last;
    rpt    = 1'b0;
    found  = 1'b0;
    idx    = 2'd0;
    free   = (state == EMPTY) | R_READY;
    others = |(REQ & ~(4'b0001 << last));
    if (RST_N && free && (REQ != 4'b0000)) begin
      // cnt==0 means last never actually won, so it gets no repeat claim under contention
      if (REQ[last] && (!others || (cnt != '0 && cnt < BURST_C))) begin
        rpt = 1'b1;
      end else begin
        for (int k = 1; k < 4; k++) begin
          idx = last + 2'(k);
          if (!found && REQ[idx]) begin
            win   = idx;
            found = 1'b1;
          end
        end
      end
      GNT = 4'b0001 << win;
    end
  end

  assign xfer = |(REQ & GNT);

  always_comb begin
    case (win)
      2'd0:    sel_dat = A;
      2'd1:    sel_dat = B;
      2'd2:    sel_dat = C;
      default: sel_dat = D;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (xfer) begin
      state_nxt = FULL;
    end else if (state == FULL && R_READY) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= EMPTY;
      r_dat <= '0;
      R_ID  <= 2'd0;
      last  <= 2'd3;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        r_dat <= sel_dat;
        R_ID  <= win;
        last  <= win;
        if (rpt) begin
          cnt <= (cnt < BURST_C) ? cnt + 1'b1 : BURST_C;
        end else begin
          cnt <= CW'(1);
        end
      end
    end
  end

  assign R       = {{DW{1'b0}}, r_dat};
  assign R_VALID = (state == FULL);
  assign en      = R_VALID | (|REQ);

endmodule

// File: tb/tb_mux_arbiter_mod.sv
// Directed bench: BURST=2 instance driven from a vector table, BURST=1 instance checked by a short round-robin sequence.
module tb_mux_arbiter_mod;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  a, b, c, d;
  logic        r_ready;

  logic [3:0]  g2_gnt,  g1_gnt;
  logic [15:0] g2_r,    g1_r;
  logic [1:0]  g2_id,   g1_id;
  logic        g2_vld,  g1_vld;
  logic        g2_en,   g1_en;

  int n_cmp = 0;
  int n_err = 0;
  int row   = 0;

  mux_arbiter_mod #(.DW(8), .BURST(2)) u_b2 (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .A(a), .B(b), .C(c), .D(d),
    .GNT(g2_gnt), .R(g2_r), .R_ID(g2_id), .R_VALID(g2_vld), .R_READY(r_ready), .en(g2_en)
  );

  mux_arbiter_mod #(.DW(8), .BURST(1)) u_b1 (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .A(a), .B(b), .C(c), .D(d),
    .GNT(g1_gnt), .R(g1_r), .R_ID(g1_id), .R_VALID(g1_vld), .R_READY(r_ready), .en(g1_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    bit [3:0]  req;
    bit        rdy;
    bit [7:0]  a;
    bit [3:0]  gnt;
    bit        vld;
    bit        chk_r;
    bit [15:0] r;
    bit [1:0]  id;
    bit        en;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(bit rs, bit [3:0] rq, bit rd, bit [7:0] av, bit [3:0] g,
                              bit v, bit cr, bit [15:0] rv, bit [1:0] iv, bit e);
    vec_t t;
    t.rst = rs; t.req = rq; t.rdy = rd; t.a = av; t.gnt = g;
    t.vld = v; t.chk_r = cr; t.r = rv; t.id = iv; t.en = e;
    return t;
  endfunction

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %0d, expected %0d", nm, row, act, exp);
    end
  endtask

  logic [3:0] exp_g [4];
  logic [7:0] exp_d [4];

  initial begin
    // reset / first grant A
    tbl[0]  = mk(0, 4'b1111, 1, 170, 4'b0000, 0, 1, 0,   0, 1);
    tbl[1]  = mk(1, 4'b1111, 1, 170, 4'b0001, 0, 0, 0,   0, 1);
    tbl[2]  = mk(1, 4'b0000, 1, 170, 4'b0000, 1, 0, 170, 0, 1);
    // A,B two-way contention with BURST=2, A already holding one grant
    tbl[3]  = mk(1, 4'b0011, 1, 170, 4'b0001, 0, 0, 0,   0, 1);
    tbl[4]  = mk(1, 4'b0011, 1, 170, 4'b0010, 1, 0, 170, 0, 1);
    tbl[5]  = mk(1, 4'b0011, 1, 170, 4'b0010, 1, 0, 1,   1, 1);
    tbl[6]  = mk(1, 4'b0011, 1, 170, 4'b0001, 1, 0, 1,   1, 1);
    tbl[7]  = mk(1, 4'b0011, 1, 170, 4'b0001, 1, 0, 170, 0, 1);
    tbl[8]  = mk(1, 4'b0011, 1, 170, 4'b0010, 1, 0, 170, 0, 1);
    // lone A: continuous grants, count saturates
    tbl[9]  = mk(1, 4'b0001, 1, 255, 4'b0001, 1, 0, 1,   1, 1);
    tbl[10] = mk(1, 4'b0001, 1, 255, 4'b0001, 1, 0, 255, 0, 1);
    tbl[11] = mk(1, 4'b0001, 1, 255, 4'b0001, 1, 0, 255, 0, 1);
    tbl[12] = mk(1, 4'b0001, 1, 255, 4'b0001, 1, 0, 255, 0, 1);
    tbl[13] = mk(1, 4'b0011, 1, 255, 4'b0010, 1, 0, 255, 0, 1);
    // C captured, then held for 5 stall cycles while D waits
    tbl[14] = mk(1, 4'b0100, 1, 170, 4'b0100, 1, 0, 1,   1, 1);
    tbl[15] = mk(1, 4'b1000, 0, 170, 4'b0000, 1, 0, 128, 2, 1);
    tbl[16] = mk(1, 4'b1000, 0, 170, 4'b0000, 1, 0, 128, 2, 1);
    tbl[17] = mk(1, 4'b1000, 0, 170, 4'b0000, 1, 0, 128, 2, 1);
    tbl[18] = mk(1, 4'b1000, 0, 170, 4'b0000, 1, 0, 128, 2, 1);
    tbl[19] = mk(1, 4'b1000, 0, 170, 4'b0000, 1, 0, 128, 2, 1);
    tbl[20] = mk(1, 4'b1000, 1, 170, 4'b1000, 1, 0, 128, 2, 1);
    tbl[21] = mk(1, 4'b0000, 1, 170, 4'b0000, 1, 0, 192, 3, 1);
    tbl[22] = mk(1, 4'b0000, 0, 170, 4'b0000, 0, 0, 0,   0, 0);
    // reset in the middle of a stall
    tbl[23] = mk(1, 4'b0100, 0, 170, 4'b0100, 0, 0, 0,   0, 1);
    tbl[24] = mk(1, 4'b0100, 0, 170, 4'b0000, 1, 0, 128, 2, 1);
    tbl[25] = mk(0, 4'b0100, 0, 170, 4'b0000, 1, 0, 128, 2, 1);
    tbl[26] = mk(1, 4'b0000, 0, 170, 4'b0000, 0, 1, 0,   0, 0);
    tbl[27] = mk(1, 4'b1111, 1, 170, 4'b0001, 0, 0, 0,   0, 1);
    tbl[28] = mk(1, 4'b0000, 1, 170, 4'b0000, 1, 0, 170, 0, 1);

    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_d = '{8'd170, 8'd1, 8'd128, 8'd192};

    rst_n = 1'b0; req = 4'b1111; r_ready = 1'b1;
    a = 8'd170; b = 8'd1; c = 8'd128; d = 8'd192;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      row     = i;
      rst_n   = tbl[i].rst;
      req     = tbl[i].req;
      r_ready = tbl[i].rdy;
      a       = tbl[i].a;
      #1;
      check("gnt", {12'd0, g2_gnt}, {12'd0, tbl[i].gnt});
      check("r_valid", {15'd0, g2_vld}, {15'd0, tbl[i].vld});
      check("en", {15'd0, g2_en}, {15'd0, tbl[i].en});
      if (tbl[i].vld || tbl[i].chk_r) begin
        check("r", g2_r, tbl[i].r);
        check("r_id", {14'd0, g2_id}, {14'd0, tbl[i].id});
      end
      @(posedge clk);
      #1;
    end

    // BURST=1 instance: strict rotation A,B,C,D,A with all four requesting
    row = 100;
    rst_n = 1'b0; req = 4'b1111; r_ready = 1'b1; a = 8'd170;
    #1;
    check("b1_gnt_rst", {12'd0, g1_gnt}, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      row = 100 + i;
      #1;
      check("b1_gnt", {12'd0, g1_gnt}, {12'd0, exp_g[i % 4]});
      check("b1_r_valid", {15'd0, g1_vld}, (i > 0) ? 16'd1 : 16'd0);
      if (i > 0) begin
        check("b1_r_id", {14'd0, g1_id}, 16'((i - 1) % 4));
        check("b1_r", g1_r, {8'd0, exp_d[(i - 1) % 4]});
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
